// File: rtl/mj32_pkg.sv
// Shared register-file constants for the mj32 core: default widths, index type, zero register.
package mj32_pkg;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned NREGS = 32;

   typedef logic [$clog2(NREGS)-1:0] reg_idx_t;

   localparam reg_idx_t REG_ZERO = '0;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one flag per register with flush > reserve > writeback-clear
// priority, plus a registered population count of the flags.
module rf_scoreboard #(
   parameter  int unsigned NREGS = mj32_pkg::NREGS,
   localparam int unsigned AW    = $clog2(NREGS)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             rsv,
   input  logic [AW-1:0]    rd,
   input  logic             wr_en,
   input  logic [AW-1:0]    rw,
   input  logic             flush,
   output logic [NREGS-1:0] pending,
   output logic [AW:0]      nbusy
);
   import mj32_pkg::*;

   logic [NREGS-1:0] pend_nxt;
   logic [AW:0]      cnt_nxt;

   // Later assignments win: a same-cycle reservation beats the writeback clear,
   // and flush beats both.
   always_comb begin
      pend_nxt = pending;
      if (wr_en) begin
         pend_nxt[rw] = 1'b0;
      end
      if (rsv && (rd != AW'(REG_ZERO))) begin
         pend_nxt[rd] = 1'b1;
      end
      if (flush) begin
         pend_nxt = '0;
      end
      pend_nxt[0] = 1'b0;
   end

   always_comb begin
      cnt_nxt = '0;
      for (int unsigned i = 0; i < NREGS; i++) begin
         cnt_nxt = cnt_nxt + (AW+1)'(pend_nxt[i]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending <= '0;
         nbusy   <= '0;
      end else begin
         pending <= pend_nxt;
         nbusy   <= cnt_nxt;
      end
   end

endmodule

// File: rtl/register_file_mp.sv
// Multi-read-port register file with x0 hardwired to zero and a pending-write scoreboard.
// Define RF_BYPASS_EN to forward same-cycle writeback data to matching read ports.
module register_file_mp #(
   parameter  int unsigned XLEN  = mj32_pkg::XLEN,
   parameter  int unsigned NREGS = mj32_pkg::NREGS,
   parameter  int unsigned NRD   = 2,
   localparam int unsigned AW    = $clog2(NREGS)
) (
   input  logic                C,
   input  logic                Rst_n,
   input  logic [XLEN-1:0]     Din,
   input  logic                we,
   input  logic [AW-1:0]       Rw,
   input  logic [NRD*AW-1:0]   Ra,
   output logic [NRD*XLEN-1:0] Da,
   output logic [NRD-1:0]      Busy,
   input  logic                rsv,
   input  logic [AW-1:0]       Rd,
   input  logic                flush,
   output logic [AW:0]         nbusy
);
   import mj32_pkg::*;

   logic [XLEN-1:0]  regs [NREGS];
   logic [NREGS-1:0] pending;
   logic             wr_en;
   logic [AW-1:0]    idx;

   assign wr_en = we && (Rw != AW'(REG_ZERO));

   // Entry 0 is cleared by reset and never written, so it always reads zero.
   always_ff @(posedge C or negedge Rst_n) begin
      if (!Rst_n) begin
         for (int unsigned i = 0; i < NREGS; i++) begin
            regs[i] <= '0;
         end
      end else if (wr_en) begin
         regs[Rw] <= Din;
      end
   end

   rf_scoreboard #(
      .NREGS (NREGS)
   ) u_scoreboard (
      .clk     (C),
      .rst_n   (Rst_n),
      .rsv     (rsv),
      .rd      (Rd),
      .wr_en   (wr_en),
      .rw      (Rw),
      .flush   (flush),
      .pending (pending),
      .nbusy   (nbusy)
   );

   always_comb begin
      Da   = '0;
      Busy = '0;
      idx  = '0;
      for (int unsigned k = 0; k < NRD; k++) begin
         idx                 = Ra[k*AW +: AW];
         Da[k*XLEN +: XLEN]  = regs[idx];
         Busy[k]             = pending[idx];
`ifdef RF_BYPASS_EN
         if (wr_en && (idx == Rw)) begin
            Da[k*XLEN +: XLEN] = Din;
            Busy[k]            = 1'b0;
         end
`endif
      end
   end

endmodule
